// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Packet-locked round-robin sharing of an async FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          wpush,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          err_overlong
);

  localparam int                 C_CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(MAX_BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [ID_WIDTH-1:0]   r_last_grant;
  logic [C_CNT_W-1:0]    r_beat_cnt;
  logic                  r_err_overlong;
  logic [ID_WIDTH-1:0]   w_pick;
  logic [ID_WIDTH-1:0]   w_cand;
  logic                  w_any_req;
  logic                  w_accept;
  logic                  w_owner_last;
  logic                  w_release;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Search starts just after the previous owner so every active requester is
  // served once before anyone is served twice.
  always_comb begin
    w_pick    = r_last_grant;
    w_cand    = r_last_grant;
    w_any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_WIDTH'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_any_req && req_valid[w_cand]) begin
        w_any_req = 1'b1;
        w_pick    = w_cand;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_owner_last = 1'b0;
    w_release    = 1'b0;
    req_ready    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_next = S_LOCK;
        end
      end
      S_LOCK: begin
        w_accept              = req_valid[r_grant_id] & ~wfull;
        w_owner_last          = req_last[r_grant_id];
        req_ready[r_grant_id] = ~wfull;
        w_release             = w_accept & (w_owner_last | (r_beat_cnt == C_LAST_BEAT));
        if (w_release) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_grant_id     <= '0;
      r_last_grant   <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt     <= '0;
      r_err_overlong <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_grant_id <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + C_CNT_W'(1);
      end
      // A release without the last flag can only be the beat-limit guard.
      if (w_release) begin
        r_last_grant <= r_grant_id;
        if (!w_owner_last) begin
          r_err_overlong <= 1'b1;
        end
      end
    end
  end

  assign wpush        = w_accept;
  assign wdata        = w_slice[r_grant_id];
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == S_LOCK);
  assign err_overlong = r_err_overlong;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Scoreboard bench for fifo_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 32;
  localparam int MAXB    = 16;
  localparam int IW      = 2;

  logic                  wclk   = 1'b0;
  logic                  wrst_n = 1'b1;
  logic                  wfull  = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_last  = '0;
  logic [NUM_REQ*DW-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  wpush;
  logic [DW-1:0]         wdata;
  logic [IW-1:0]         grant_id;
  logic                  busy;
  logic                  err_overlong;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t            exp_q[$];
  logic [DW:0]     src_q[NUM_REQ][$];
  time             push_t[$];
  int              tests      = 0;
  int              fails      = 0;
  int              push_count = 0;
  logic [NUM_REQ-1:0] hs = '0;

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MAXB),
    .ID_WIDTH  (IW)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wfull       (wfull),
    .wpush       (wpush),
    .wdata       (wdata),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_overlong(err_overlong)
  );

  always #5 wclk = ~wclk;

  function automatic logic [DW-1:0] mk(input int r, input int k);
    return DW'(32'hD000_0000 | (r << 16) | k);
  endfunction

  // Monitor: every push is checked against the head of the scoreboard.
  always @(negedge wclk) begin : mon
    exp_t e;
    hs = req_valid & req_ready;
    if (wpush === 1'b1) begin
      push_count++;
      push_t.push_back($time);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_push: wdata=%h grant_id=%0d, required no push", wdata, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (wdata !== e.data || grant_id !== e.id || wfull !== 1'b0) begin
          fails++;
          $display("FAIL push_data: wdata=%h id=%0d wfull=%b, required wdata=%h id=%0d wfull=0",
                   wdata, grant_id, wfull, e.data, e.id);
        end
      end
    end
  end

  // Requester models: pop on handshake, present the queue head.
  initial begin
    forever begin
      @(posedge wclk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = src_q[i][0][DW];
          req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  task automatic send(input int r, input int n, input bit use_last, input int k0, input int nexp);
    for (int b = 0; b < n; b++) begin
      src_q[r].push_back({(use_last && b == n - 1), mk(r, k0 + b)});
      if (b < nexp) exp_q.push_back({IW'(r), mk(r, k0 + b)});
    end
  endtask

  task automatic expect_beats(input int r, input int k0, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({IW'(r), mk(r, k0 + b)});
  endtask

  task automatic wait_push(input int target, input string nm);
    int n = 0;
    while (push_count < target && n < 300) begin
      @(negedge wclk);
      #1;
      n++;
    end
    tests++;
    if (push_count < target) begin
      fails++;
      $display("FAIL %s_timeout: pushes=%0d, required %0d", nm, push_count, target);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #12;
    wrst_n = 1'b0;
    #1;
    tests++;
    if (wpush !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: wpush=%b ready=%b busy=%b, required 0 0000 0", wpush, req_ready, busy);
    end
    tests++;
    if (grant_id !== 2'd0 || err_overlong !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: grant_id=%0d err=%b, required 0 0", grant_id, err_overlong);
    end
    repeat (2) @(posedge wclk);
    #2 wrst_n = 1'b1;
    repeat (2) @(negedge wclk);
    tests++;
    if (busy !== 1'b0 || wpush !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b wpush=%b, required 0 0", busy, wpush);
    end
  endtask

  task automatic test_round_robin();
    time t0;
    int  base = push_count;
    @(posedge wclk);
    t0 = $time;
    push_t.delete();
    send(0, 1, 1, 16'h10, 1);
    send(1, 1, 1, 16'h10, 1);
    send(2, 1, 1, 16'h10, 1);
    send(3, 1, 1, 16'h10, 1);
    send(0, 1, 1, 16'h11, 1);
    wait_push(base + 5, "rr");
    tests++;
    if (push_t.size() < 1 || push_t[0] != t0 + 15) begin
      fails++;
      $display("FAIL rr_latency: first push at %0t, required %0t", push_t.size() ? push_t[0] : 0, t0 + 15);
    end
    for (int i = 1; i < push_t.size() && i < 5; i++) begin
      tests++;
      if (push_t[i] - push_t[i-1] != 20) begin
        fails++;
        $display("FAIL rr_spacing: gap %0t, required 20", push_t[i] - push_t[i-1]);
      end
    end
  endtask

  task automatic test_packet_lock();
    int base = push_count;
    @(posedge wclk);
    push_t.delete();
    send(1, 3, 1, 16'h20, 3);
    send(2, 1, 1, 16'h20, 1);
    send(0, 1, 1, 16'h20, 1);
    wait_push(base + 5, "lock");
    if (push_t.size() >= 5) begin
      tests++;
      if (push_t[1] - push_t[0] != 10 || push_t[2] - push_t[1] != 10 ||
          push_t[3] - push_t[2] != 20 || push_t[4] - push_t[3] != 20) begin
        fails++;
        $display("FAIL lock_timing: gaps %0t %0t %0t %0t, required 10 10 20 20",
                 push_t[1] - push_t[0], push_t[2] - push_t[1], push_t[3] - push_t[2], push_t[4] - push_t[3]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int base = push_count;
    @(posedge wclk);
    send(0, 6, 1, 16'h30, 6);
    wait_push(base + 2, "bp_start");
    @(posedge wclk);
    #2 wfull = 1'b1;
    repeat (5) begin
      @(negedge wclk);
      tests++;
      if (wpush !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1 || grant_id !== 2'd0) begin
        fails++;
        $display("FAIL bp_hold: wpush=%b ready=%b busy=%b id=%0d, required 0 0000 1 0",
                 wpush, req_ready, busy, grant_id);
      end
    end
    @(posedge wclk);
    #2 wfull = 1'b0;
    wait_push(base + 6, "bp_resume");
    repeat (3) @(negedge wclk);
    tests++;
    if (push_count !== base + 6) begin
      fails++;
      $display("FAIL bp_count: pushes=%0d, required %0d", push_count - base, 6);
    end
  endtask

  task automatic test_overlong();
    int base = push_count;
    int n    = 0;
    @(posedge wclk);
    send(3, 20, 0, 16'h40, MAXB);
    while (!(busy === 1'b1 && grant_id === 2'd3) && n < 20) begin
      @(negedge wclk);
      n++;
    end
    tests++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || err_overlong !== 1'b0) begin
      fails++;
      $display("FAIL ovl_grant: busy=%b id=%0d err=%b, required 1 3 0", busy, grant_id, err_overlong);
    end
    @(posedge wclk);
    send(0, 1, 1, 16'h41, 1);
    send(1, 1, 1, 16'h41, 1);
    expect_beats(3, 16'h40 + MAXB, 20 - MAXB);
    wait_push(base + 22, "ovl");
    tests++;
    if (err_overlong !== 1'b1) begin
      fails++;
      $display("FAIL ovl_err: err_overlong=%b, required 1", err_overlong);
    end
    repeat (3) begin
      @(negedge wclk);
      tests++;
      if (busy !== 1'b1 || grant_id !== 2'd3 || wpush !== 1'b0 || err_overlong !== 1'b1) begin
        fails++;
        $display("FAIL ovl_frozen: busy=%b id=%0d wpush=%b err=%b, required 1 3 0 1",
                 busy, grant_id, wpush, err_overlong);
      end
    end
  endtask

  task automatic test_midburst_reset();
    int base;
    @(posedge wclk);
    #3 wrst_n = 1'b0;
    flush();
    #1;
    tests++;
    if (err_overlong !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_clear: err=%b busy=%b, required 0 0", err_overlong, busy);
    end
    @(posedge wclk);
    #2 wrst_n = 1'b1;
    base = push_count;
    @(posedge wclk);
    send(1, 1, 1, 16'h50, 1);
    wait_push(base + 1, "mid_pre");
    base = push_count;
    @(posedge wclk);
    send(2, 4, 1, 16'h60, 2);
    wait_push(base + 2, "mid_burst");
    @(posedge wclk);
    #3 wrst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || wpush !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b wpush=%b ready=%b id=%0d, required 0 0 0000 0",
               busy, wpush, req_ready, grant_id);
    end
    flush();
    base = push_count;
    @(posedge wclk);
    send(0, 1, 1, 16'h70, 1);
    send(1, 1, 1, 16'h70, 1);
    send(2, 1, 1, 16'h70, 1);
    #2 wrst_n = 1'b1;
    wait_push(base + 3, "mid_after");
    repeat (3) @(negedge wclk);
    tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL mid_drain: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_back_pressure();
    test_overlong();
    test_midburst_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
